// File: rtl/shift_add_pkg.sv
// rtl/shift_add_pkg.sv - shared state encoding and sizing helpers for shift_add_mult
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  // Counter must hold WIDTH itself so the last increment never wraps.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// rtl/adder_nbit.sv - parameterised ripple-carry adder built from full_adder cells
module adder_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential unsigned shift-add multiplier, one bit per clock
// SHIFT_ADD_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero
module shift_add_mult
  import shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifdef SHIFT_ADD_EARLY_TERM_EN
  localparam logic [CW-1:0] W_CNT = CW'(WIDTH);
`endif

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fin;

  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  adder_nbit #(.WIDTH(WIDTH)) u_add (
    .a   (acc_hi),
    .b   (mcand_q),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  // Carry becomes the shifted-in MSB, so nothing is lost at the top.
  always_comb begin
    acc_d = (2*WIDTH)'({mplier_q[0] & cout, (mplier_q[0] ? sum : acc_hi), acc_lo} >> 1);
    fin   = (cnt_q == LAST_CNT);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    if (mplier_q == '0) begin
      acc_d = acc_q >> (W_CNT - cnt_q);
      fin   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (fin) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed and sweep checks of shift_add_mult at WIDTH 4 and 8
module tb_shift_add_mult;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4;
  logic [7:0] product4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  shift_add_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  // Edges after the accepting edge until done is visible (#1 after that edge).
  function automatic int exp_lat(input int w, input int bv);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    int bl = 0;
    for (int i = 0; i < w; i++) if (bv[i]) bl = i + 1;
    return (bl + 1 < w) ? bl + 1 : w;
`else
    return w;
`endif
  endfunction

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb,
                     output logic [7:0] p, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
    end
    p = product4;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    p = product8;
  endtask

  task automatic test_reset;
    bit saw_done;
    #1;
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy4); end
    n_vec++; if (done4 !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done4); end
    n_vec++; if (product4 !== 8'h00) begin n_err++; $display("FAIL reset_product got=%h want=00", product4); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL midrun_busy got=%b want=1", busy4); end
    rst = 1'b1;
    #1;
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy4); end
    n_vec++; if (done4 !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b want=0", done4); end
    n_vec++; if (product4 !== 8'h00) begin n_err++; $display("FAIL abort_product got=%h want=00", product4); end
    @(negedge clk) rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
  endtask

  task automatic test_basic;
    int busy_cnt, lat;
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    busy_cnt = (busy4 === 1'b1) ? 1 : 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
      if (busy4 === 1'b1) busy_cnt++;
    end
    n_vec++; if (lat != exp_lat(4, 5)) begin n_err++; $display("FAIL basic_latency got=%0d want=%0d", lat, exp_lat(4, 5)); end
    n_vec++; if (product4 !== 8'd15) begin n_err++; $display("FAIL basic_product got=%0d want=15", product4); end
    n_vec++; if (busy_cnt != exp_lat(4, 5)) begin n_err++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cnt, exp_lat(4, 5)); end
    n_vec++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL basic_busy_in_done got=%b want=0", busy4); end
    @(posedge clk); #1;
    n_vec++; if (done4 !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b want=0", done4); end
    n_vec++; if (product4 !== 8'd15) begin n_err++; $display("FAIL basic_product_hold got=%0d want=15", product4); end
  endtask

  task automatic test_carry;
    logic [7:0] p; int lat;
    op4(4'hF, 4'hF, p, lat);
    n_vec++; if (p !== 8'hE1) begin n_err++; $display("FAIL carry_product got=%h want=e1", p); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL carry_latency got=%0d want=4", lat); end
  endtask

  task automatic test_zero;
    logic [7:0] p; int lat;
    op4(4'd0, 4'd9, p, lat);
    n_vec++; if (p !== 8'd0) begin n_err++; $display("FAIL zero_a_product got=%0d want=0", p); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL zero_a_latency got=%0d want=4", lat); end
    op4(4'd7, 4'd0, p, lat);
    n_vec++; if (p !== 8'd0) begin n_err++; $display("FAIL zero_b_product got=%0d want=0", p); end
`ifdef SHIFT_ADD_EARLY_TERM_EN
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL zero_b_latency got=%0d want=1", lat); end
`else
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL zero_b_latency got=%0d want=4", lat); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd6; start4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'hF; b4 = 4'hF;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
    end
    n_vec++; if (product4 !== 8'd12) begin n_err++; $display("FAIL b2b_first_product got=%0d want=12", product4); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL b2b_first_latency got=%0d want=4", lat); end
    a4 = 4'd9; b4 = 4'd4;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'h1; b4 = 4'h1;
    n_vec++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy got=%b want=1", busy4); end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done4) break;
    end
    n_vec++; if (product4 !== 8'd36) begin n_err++; $display("FAIL b2b_second_product got=%0d want=36", product4); end
    n_vec++; if (lat != 4) begin n_err++; $display("FAIL b2b_second_latency got=%0d want=4", lat); end
  endtask

  task automatic test_exhaustive;
    logic [7:0] p; logic [15:0] p8; int lat;
    logic [7:0] ra, rb;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        op4(4'(ai), 4'(bi), p, lat);
        n_vec++;
        if (p !== 8'(ai * bi) || lat != exp_lat(4, bi)) begin
          n_err++;
          $display("FAIL w4_%0dx%0d got=%0d/lat%0d want=%0d/lat%0d", ai, bi, p, lat, ai * bi, exp_lat(4, bi));
        end
      end
    end
    for (int k = 0; k < 42; k++) begin
      if (k == 0)      begin ra = 8'hFF; rb = 8'hFF; end
      else if (k == 1) begin ra = 8'h80; rb = 8'h01; end
      else begin ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); end
      op8(ra, rb, p8, lat);
      n_vec++;
      if (p8 !== 16'(ra * rb) || lat != exp_lat(8, int'(rb))) begin
        n_err++;
        $display("FAIL w8_%0dx%0d got=%0d/lat%0d want=%0d/lat%0d", ra, rb, p8, lat, 16'(ra * rb), exp_lat(8, int'(rb)));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_zero;
    test_back_to_back;
    test_exhaustive;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
